// File: rtl/block_mem_responder.sv
// Clocked block-granular main-memory responder: one 128-bit read or write-back
// at a time, completed a fixed LATENCY cycles after acceptance via valid/ready.
module block_mem_responder #(
    parameter int ADDR_WIDTH = 10,
    parameter int BLOCK_BITS = 128,
    parameter int LATENCY    = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  mem_lock,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [BLOCK_BITS-1:0] req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [BLOCK_BITS-1:0] resp_rdata
);

    localparam int IDX_WIDTH  = ADDR_WIDTH - 4;
    localparam int NUM_BLOCKS = 1 << IDX_WIDTH;
    localparam int WORDS      = BLOCK_BITS / 32;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } stateT;

    stateT                 state;
    stateT                 nextState;
    logic [3:0]            counter;
    logic [IDX_WIDTH-1:0]  latchIdx;
    logic                  latchWrite;
    logic [BLOCK_BITS-1:0] latchWdata;
    logic [BLOCK_BITS-1:0] memArray [NUM_BLOCKS];
    logic                  accept;
    logic                  unusedAddrBits;

    // The low nibble is a byte offset inside the block and never selects data.
    assign unusedAddrBits = ^req_addr[3:0];

    assign accept     = req_valid && req_ready;
    assign resp_valid = (state == RESP);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= nextState;
    end

    // NOTE: every variable assigned here gets a default first so no latch is inferred.
    always_comb begin
        nextState = state;
        req_ready = 1'b0;
        unique case (state)
            IDLE: begin
                req_ready = !mem_lock;
                if (req_valid && !mem_lock) nextState = BUSY;
            end
            BUSY: if (counter == 4'd0) nextState = RESP;
            RESP: if (resp_ready) nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // NOTE: the array is built from flops rather than a RAM macro because reset
    // must restore every word to its index value, which a RAM cannot do.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int b = 0; b < NUM_BLOCKS; b++) begin
                for (int w = 0; w < WORDS; w++) begin
                    memArray[IDX_WIDTH'(b)][w*32 +: 32] <= 32'(b * WORDS + w);
                end
            end
            resp_rdata <= '0;
            latchIdx   <= '0;
            latchWrite <= 1'b0;
            latchWdata <= '0;
            counter    <= 4'd0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        latchIdx   <= req_addr[ADDR_WIDTH-1:4];
                        latchWrite <= req_write;
                        latchWdata <= req_wdata;
                        counter    <= 4'(LATENCY - 1);
                    end
                end
                BUSY: begin
                    if (counter == 4'd0) begin
                        if (latchWrite) begin
                            memArray[latchIdx] <= latchWdata;
                            resp_rdata         <= latchWdata;
                        end else begin
                            resp_rdata <= memArray[latchIdx];
                        end
                    end else begin
                        counter <= counter - 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/block_mem_responder.md
Name: block_mem_responder

Overview:
Clocked main-memory responder on the block side of the cache-to-memory interface. It accepts one 128-bit block read or write-back request at a time and completes it after a fixed access latency. It returns the response through a valid/ready handshake and replaces the combinational memory model behind the cache. The cache's miss/write-back controller is the initiator; this block is the responder.

Parameters:
ADDR_WIDTH, 10, byte address width; block index = addr[ADDR_WIDTH-1:4]
BLOCK_BITS, 128, block size in bits (4 x 32-bit words); fixed at 128
LATENCY, 4, cycles from request acceptance to resp_valid; legal range 1..15

Ports:
clock  input  1  system clock; all state changes on the rising edge
reset  input  1  asynchronous, active-high reset
mem_lock  input  1  when high, no new request is accepted; an in-flight request is unaffected
req_valid  input  1  request present
req_ready  output  1  responder can accept a request this cycle
req_write  input  1  1 = write-back block, 0 = read block
req_addr  input  ADDR_WIDTH  byte address; bits [3:0] ignored
req_wdata  input  BLOCK_BITS  write-back data; word 0 is in bits [31:0]
resp_valid  output  1  response available
resp_ready  input  1  initiator accepts the response
resp_rdata  output  BLOCK_BITS  read data, or an echo of the written data for writes

Behaviour:
- Storage: 2^(ADDR_WIDTH-4) blocks of 128 bits (64 for the default).
- On reset, 32-bit word k of the flat array (k = block*4 + word) is initialised to k. Block b therefore holds {4b+3, 4b+2, 4b+1, 4b}.
- Reset values: state IDLE, resp_valid=0, resp_rdata=0, latched request fields=0, counter=0. req_ready = !mem_lock.
- State IDLE:
  - req_ready = !mem_lock.
  - On req_valid && req_ready, latch block index, req_write and req_wdata.
  - Load counter with LATENCY-1 and go to BUSY.
- State BUSY:
  - req_ready=0.
  - The counter decrements each cycle.
  - On the edge where counter==0: for a write, store the latched data and set resp_rdata = latched wdata; for a read, set resp_rdata = array[block]. Then set resp_valid=1 and go to RESP.
  - resp_valid therefore rises exactly LATENCY edges after the acceptance edge.
- State RESP:
  - req_ready=0.
  - resp_valid and resp_rdata are held stable until resp_ready is sampled high.
  - On that edge: resp_valid=0 and go to IDLE. The next request can be accepted on the following edge at the earliest; no same-cycle turnaround.
- Requests presented while in BUSY or RESP are not accepted and have no effect. The initiator must hold req_valid and its fields until req_ready is high.
- mem_lock rising during BUSY or RESP does not stall or abort the current transaction. It only gates acceptance in IDLE.
- A read issued after a completed write to the same block returns the new data. There is no internal buffering beyond one request.
- Address aliasing: bits [3:0] never select data; addresses 0x000 and 0x00F hit the same block.
- Reset asserted mid-transaction aborts immediately: return to IDLE, resp_valid=0, array reinitialised, the pending write is discarded.
- A counter of 4 bits is sufficient; LATENCY=1 goes IDLE -> BUSY(counter 0) -> RESP.
- Only resp_rdata and the array are written by datapath logic. No combinational path from req_* to resp_*.

Test Plan:
- Reset, then read req_addr=10'h010 with LATENCY=4 -> req_ready drops the edge after acceptance. resp_valid rises 4 edges after acceptance with resp_rdata = 128'h00000007_00000006_00000005_00000004.
- Write req_addr=10'h3F0, wdata=128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF; then read 10'h3FC -> write response echoes the wdata; the read returns the same 128-bit value.
- Hold resp_ready=0 for 6 cycles after resp_valid -> resp_valid and resp_rdata are stable throughout, req_ready=0, and a second req_valid pulse is ignored. Release resp_ready -> IDLE next edge.
- Assert mem_lock with req_valid=1 for 5 cycles -> req_ready=0 and no acceptance. Deassert -> accepted that cycle. mem_lock raised during BUSY -> response still arrives at LATENCY.
- Accept a write to 10'h020, then pulse reset on cycle 2 of BUSY -> resp_valid=0, req_ready=1. A subsequent read of 10'h020 returns the initial value 128'h0000000B_0000000A_00000009_00000008.
- Back-to-back reads of blocks 0 and 63 with resp_ready tied high -> each response arrives LATENCY edges after its acceptance, with one idle edge between transactions.
